// File: rtl/shadow_register_bank.sv
// Double-buffered register bank: multi-port byte-masked writes land in a
// shadow copy that a single commit pulse publishes to the active copy.
module shadow_register_bank #(
  parameter int WIDTH = 32,
  parameter int NUM_REGS = 8,
  parameter int NUM_PORTS = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  localparam int AW = $clog2(NUM_REGS),
  localparam int BE = WIDTH / 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_PORTS-1:0]     load,
  input  logic [NUM_PORTS*AW-1:0]  wr_addr,
  input  logic [NUM_PORTS*WIDTH-1:0] wr_data,
  input  logic [NUM_PORTS*BE-1:0]  wr_be,
  input  logic                     commit,
  input  logic [AW-1:0]            rd_addr,
  output logic [WIDTH-1:0]         Q,
  output logic [WIDTH-1:0]         shadow_q,
  output logic [NUM_REGS-1:0]      dirty,
  output logic                     pending,
  output logic [15:0]              commit_count
);

  logic [WIDTH-1:0]    shadow_bank_q [NUM_REGS];
  logic [WIDTH-1:0]    shadow_bank_d [NUM_REGS];
  logic [WIDTH-1:0]    active_bank_q [NUM_REGS];
  logic [WIDTH-1:0]    active_bank_d [NUM_REGS];
  logic [NUM_REGS-1:0] dirty_q, dirty_d;
  logic [NUM_REGS-1:0] wr_hit;
  logic                pending_q, pending_d;
  logic [15:0]         count_q, count_d;
  logic [AW-1:0]       rd_addr_q, rd_addr_d;
  logic                rd_ok;

  // Ports are applied highest index first so the lowest port wins each lane.
  always_comb begin
    shadow_bank_d = shadow_bank_q;
    wr_hit = '0;
    for (int p = NUM_PORTS - 1; p >= 0; p--) begin
      if (!load[p] && int'(wr_addr[p*AW +: AW]) < NUM_REGS) begin
        for (int i = 0; i < NUM_REGS; i++) begin
          if (wr_addr[p*AW +: AW] == AW'(i)) begin
            for (int b = 0; b < BE; b++) begin
              if (wr_be[p*BE + b]) begin
                shadow_bank_d[i][b*8 +: 8] = wr_data[p*WIDTH + b*8 +: 8];
                wr_hit[i] = 1'b1;
              end
            end
          end
        end
      end
    end
  end

  always_comb begin
    active_bank_d = commit ? shadow_bank_d : active_bank_q;
    dirty_d = commit ? '0 : (dirty_q | wr_hit);
    pending_d = |dirty_q;
    count_d = commit ? count_q + 16'd1 : count_q;
    rd_addr_d = rd_addr;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        shadow_bank_q[i] <= RESET_VALUE;
        active_bank_q[i] <= RESET_VALUE;
      end
      dirty_q   <= '0;
      pending_q <= 1'b0;
      count_q   <= '0;
      rd_addr_q <= '0;
    end else begin
      shadow_bank_q <= shadow_bank_d;
      active_bank_q <= active_bank_d;
      dirty_q   <= dirty_d;
      pending_q <= pending_d;
      count_q   <= count_d;
      rd_addr_q <= rd_addr_d;
    end
  end

  assign rd_ok        = int'(rd_addr_q) < NUM_REGS;
  assign Q            = rd_ok ? active_bank_q[rd_addr_q] : '0;
  assign shadow_q     = rd_ok ? shadow_bank_q[rd_addr_q] : '0;
  assign dirty        = dirty_q;
  assign pending      = pending_q;
  assign commit_count = count_q;

endmodule
